// File: rtl/bus_owner_arbiter_if.sv
// Shared-bus ownership signals between the arbiter and the bus agents.
// The arbiter uses the master modport and the agents use the slave modport.
interface bus_owner_arbiter_if #(
    parameter int N_AGENTS = 4,
    parameter int OWNER_W  = 2
);
    logic [N_AGENTS-1:0] req;
    logic [N_AGENTS-1:0] gnt;
    logic [N_AGENTS-1:0] send_data;
    logic [N_AGENTS-1:0] rcv_data;
    logic [OWNER_W-1:0]  owner;
    logic                bus_idle;

    modport master (
        input  req,
        output gnt, send_data, rcv_data, owner, bus_idle
    );

    modport slave (
        output req,
        input  gnt, send_data, rcv_data, owner, bus_idle
    );
endinterface

// File: rtl/bus_owner_arbiter.sv
// Round-robin bus owner arbiter. A dead turnaround gap separates any two
// owners, and every per-agent send/receive enable is a registered output.

module bus_owner_lane #(
    parameter int OWNER_W = 2,
    parameter int LANE    = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               own_nxt,
    input  logic [OWNER_W-1:0] owner_nxt,
    output logic               gnt,
    output logic               rcv
);
    logic hit;

    assign hit = (owner_nxt == OWNER_W'(LANE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt <= 1'b0;
            rcv <= 1'b0;
        end else begin
            gnt <= own_nxt && hit;
            rcv <= own_nxt && !hit;
        end
    end
endmodule

module bus_owner_arbiter #(
    parameter int N_AGENTS  = 4,
    parameter int OWNER_W   = 2,
    parameter int MAX_HOLD  = 8,
    parameter int TA_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    bus_owner_arbiter_if.master  bus
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TA_W   = $clog2(TA_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [TA_W-1:0]    TA_LAST   = TA_W'(TA_CYCLES - 1);
    localparam logic [OWNER_W-1:0] LAST_IDX  = OWNER_W'(N_AGENTS - 1);
    localparam logic [OWNER_W:0]   N_EXT     = (OWNER_W+1)'(N_AGENTS);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t              state, state_nxt;
    logic [OWNER_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [OWNER_W-1:0]  owner_q, owner_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [TA_W-1:0]     ta_cnt, ta_nxt;
    logic                own_nxt;
    logic                bus_idle_q;

    logic [OWNER_W-1:0]  win;
    logic                win_vld;
    logic [OWNER_W:0]    cand_w;
    logic [OWNER_W-1:0]  cand;

    logic [N_AGENTS-1:0] gnt_q;
    logic [N_AGENTS-1:0] rcv_q;

    // First requester at or after rr_ptr, wrapping modulo N_AGENTS.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand_w  = '0;
        cand    = '0;
        for (int i = 0; i < N_AGENTS; i++) begin
            cand_w = {1'b0, rr_ptr} + (OWNER_W+1)'(i);
            if (cand_w >= N_EXT)
                cand_w = cand_w - N_EXT;
            cand = cand_w[OWNER_W-1:0];
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner_q;
        hold_nxt   = hold_cnt;
        ta_nxt     = ta_cnt;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = OWN;
                    owner_nxt = win;
                    hold_nxt  = '0;
                end
            end
            OWN: begin
                // Release and timeout share one exit; the old owner drops to lowest priority.
                if (!bus.req[owner_q] || hold_cnt == HOLD_LAST) begin
                    state_nxt  = TURN;
                    ta_nxt     = '0;
                    hold_nxt   = '0;
                    rr_ptr_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + OWNER_W'(1);
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            TURN: begin
                if (ta_cnt == TA_LAST) begin
                    ta_nxt = '0;
                    if (win_vld) begin
                        state_nxt = OWN;
                        owner_nxt = win;
                        hold_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    ta_nxt = ta_cnt + TA_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign own_nxt = (state_nxt == OWN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner_q    <= '0;
            hold_cnt   <= '0;
            ta_cnt     <= '0;
            bus_idle_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            owner_q    <= own_nxt ? owner_nxt : '0;
            hold_cnt   <= hold_nxt;
            ta_cnt     <= ta_nxt;
            bus_idle_q <= !own_nxt;
        end
    end

    for (genvar g = 0; g < N_AGENTS; g++) begin : g_lane
        bus_owner_lane #(
            .OWNER_W (OWNER_W),
            .LANE    (g)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .own_nxt   (own_nxt),
            .owner_nxt (owner_nxt),
            .gnt       (gnt_q[g]),
            .rcv       (rcv_q[g])
        );
    end

    assign bus.gnt       = gnt_q;
    assign bus.send_data = gnt_q;
    assign bus.rcv_data  = rcv_q;
    assign bus.owner     = owner_q;
    assign bus.bus_idle  = bus_idle_q;

    a_onehot_gnt: assert property (@(posedge clock) disable iff (reset) $onehot0(gnt_q));
    a_no_overlap: assert property (@(posedge clock) disable iff (reset) (gnt_q & rcv_q) == '0);
endmodule

// File: doc/bus_owner_arbiter.md
Name: bus_owner_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 32-bit bidirectional data bus. Grants bus ownership to one of N agents and drives each agent's send_data / rcv_data tri-state enables. Inserts a turnaround gap between owners so that two drivers never overlap. Sits beside the bus interface instances and drives their send_data/rcv_data inputs directly.

Parameters:
N_AGENTS, 4, number of requesting agents sharing the bus
OWNER_W, 2, width of owner index (log2 of N_AGENTS)
MAX_HOLD, 8, maximum consecutive cycles one agent may hold the bus per grant
TA_CYCLES, 1, dead cycles (no driver) between release and next grant; must be >= 1

Ports:
clock  input  1  single system clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
req  input  N_AGENTS  per-agent bus request; held high while agent wants the bus
gnt  output  N_AGENTS  one-hot grant; at most one bit high
send_data  output  N_AGENTS  per-agent driver enable; equals gnt
rcv_data  output  N_AGENTS  per-agent receive enable; high for every non-owner while the bus is owned
owner  output  OWNER_W  index of the current owner; 0 when no owner
bus_idle  output  1  high when no agent is granted (IDLE or TURNAROUND)

Behaviour:
- All outputs are registered and change on rising clock edges only. There are no combinational paths from req to outputs.
- Reset (asynchronous, any time):
  - gnt, send_data and rcv_data go to 0; owner goes to 0; bus_idle goes to 1.
  - State goes to IDLE, round-robin pointer rr_ptr to 0, hold counter to 0.
  - Reset asserted mid-grant drops all enables immediately, without waiting for a clock edge.
- States: IDLE, OWN, TURN.
- IDLE:
  - Outputs are 0 and bus_idle=1.
  - If req != 0 at a clock edge, choose the winner and enter OWN on that edge.
  - The winner is the first asserted req index searching rr_ptr, rr_ptr+1, ... modulo N_AGENTS.
  - Latency: req sampled at edge k produces gnt visible after edge k.
- OWN:
  - gnt[owner]=1 and send_data[owner]=1.
  - rcv_data = ~gnt, one bit per agent, so all other agents receive.
  - owner holds the index; bus_idle=0.
  - hold_cnt increments every cycle in OWN, starting from 0 on entry.
  - Exit to TURN on the edge where req[owner]==0 or hold_cnt==MAX_HOLD-1.
    - Release takes priority; both conditions together count as one exit.
  - On exit: rr_ptr = owner+1 modulo N_AGENTS, which gives the previous owner lowest priority.
- TURN:
  - All enables are 0, bus_idle=1, owner=0.
  - ta_cnt counts TA_CYCLES cycles.
  - On the last TURN cycle: if req != 0, enter OWN directly using the round-robin rule; otherwise enter IDLE.
  - req changes during TURN are sampled only on the final TURN cycle.
- Invariants:
  - popcount(gnt) <= 1.
  - send_data & rcv_data == 0.
  - There is never a cycle in which two different agents have send_data=1, including across an owner change.
- A timed-out owner that still requests re-competes at lowest priority. If it is the only requester, it is re-granted after TURN.
- req of the current owner dropping for one cycle ends the grant; re-raising it requires a new arbitration.

Test Plan:
- Reset/idle: hold reset 3 cycles with req=4'b1111 -> gnt=0, send_data=0, rcv_data=0, bus_idle=1. Assert reset mid-OWN between edges -> enables drop to 0 before the next edge.
- Single requester: req=4'b0100 at edge 5, dropped at edge 8 -> gnt=4'b0100 and rcv_data=4'b1011 from edge 5 to edge 8; TURN for 1 cycle; then IDLE with owner=0.
- Round-robin fairness: req=4'b1111 held continuously, MAX_HOLD=8 -> owners 0,1,2,3,0. Each owns exactly 8 cycles, separated by 1 idle cycle each.
- Timeout lone agent: req=4'b0010 held 30 cycles -> grants of 8 cycles each separated by 1-cycle TURN; owner=1 throughout each grant.
- Release vs priority: owner 2 releases while req=4'b1001 -> next owner is 3 (rr_ptr=3), then 0.
- Contention check: random req for 10,000 cycles -> at no cycle is popcount(send_data) > 1; send_data & rcv_data==0 always; at least TA_CYCLES idle cycles between any two distinct send_data bits.
